// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- RV32 data memory behind a valid/ready request/response handshake.
//
// Services one load or store at a time (byte/half/word, signed or unsigned,
// little-endian) against a 2^ADDR_W byte local RAM. Illegal funct3 and
// out-of-range accesses come back as an error response with no side effect.
//
// Optional feature macro: DMEM_MISALIGN_EN
//   defined   : misaligned half/word accesses are split into two word beats
//               (IDLE -> BEAT2 -> RSP, response latency 2)
//   undefined : misaligned half/word accesses return rsp_err at latency 1
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset (control state and outputs)
//   req_valid  in   request present
//   req_ready  out  block can accept a request (only in IDLE, low in reset)
//   req_we     in   1 = store, 0 = load
//   req_funct3 in   RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr   in   byte address
//   req_wdata  in   store data, LSB-aligned
//   rsp_valid  out  response present (RSP state)
//   rsp_ready  in   consumer accepts response
//   rsp_rdata  out  load result, extended per funct3; 0 for stores and errors
//   rsp_err    out  access rejected
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 1 << IW;
`ifdef DMEM_MISALIGN_EN
  // Byte lanes of the two-word window a split access can touch.
  localparam int LANES = 8;
`else
  localparam int LANES = 4;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef DMEM_MISALIGN_EN
    BEAT2 = 2'd1,
`endif
    RSP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic [IW-1:0]        idx;
  logic [1:0]           off;
  logic [2:0]           size_m1;
  logic                 f3_ok;
  logic                 range_ok;
  logic                 misaligned;
  logic                 acc_err;
  logic [LANES-1:0]     lane_mask;
  logic [8*LANES-1:0]   lane_data;

  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic [3:0]           wr_be;
  logic [31:0]          wr_data;
  logic [IW-1:0]        rd_idx;
  logic [1:0]           rd_off;
  logic [2:0]           rd_f3;
  logic [31:0]          rd_word;
  logic [8*LANES-1:0]   rd_cat;
  logic [31:0]          load_val;

  logic [31:0]          mem [DEPTH];

`ifdef DMEM_MISALIGN_EN
  logic                 we_q;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic [IW-1:0]        hi_idx_q;
  logic [3:0]           hi_be_q;
  logic [31:0]          hi_data_q;
  logic [31:0]          lo_q;
`endif

  assign req_ready = reset_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign accept    = req_valid && req_ready;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Request decode: legality, range, alignment and byte-lane placement.
  always_comb begin
    // NOTE: every combinational output is assigned a default before any
    // conditional update; a path that leaves a variable unassigned infers a latch.
    idx     = req_addr[ADDR_W-1:2];
    off     = req_addr[1:0];
    case (req_funct3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase

    if (req_we) f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        f3_ok = !((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111));

    // Crossing the top can only happen from the last word of the array.
    range_ok   = (req_addr[31:ADDR_W] == '0) && !((&idx) && (({1'b0, off} + size_m1) > 3'd3));
    misaligned = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
`ifdef DMEM_MISALIGN_EN
    acc_err    = !f3_ok || !range_ok;
`else
    acc_err    = !f3_ok || !range_ok || misaligned;
`endif

    lane_mask = '0;
    lane_mask[0] = 1'b1;
    if (size_m1 != 3'd0) lane_mask[1] = 1'b1;
    if (size_m1 == 3'd3) lane_mask[3:2] = 2'b11;
    lane_mask = lane_mask << off;

    lane_data = '0;
    lane_data[31:0] = req_wdata;
    lane_data = lane_data << {off, 3'b000};
  end

  // Single memory port: the acceptance cycle owns it, except in BEAT2.
  always_comb begin
    wr_en   = accept && req_we && !acc_err;
    wr_idx  = idx;
    wr_be   = lane_mask[3:0];
    wr_data = lane_data[31:0];
    rd_idx  = idx;
    rd_off  = off;
    rd_f3   = req_funct3;
`ifdef DMEM_MISALIGN_EN
    if (state_q == BEAT2) begin
      wr_en   = we_q;
      wr_idx  = hi_idx_q;
      wr_be   = hi_be_q;
      wr_data = hi_data_q;
      rd_idx  = hi_idx_q;
      rd_off  = off_q;
      rd_f3   = f3_q;
    end
`endif
  end

  assign rd_word = mem[rd_idx];
`ifdef DMEM_MISALIGN_EN
  assign rd_cat = (state_q == BEAT2) ? {rd_word, lo_q} : {32'h0, rd_word};
`else
  assign rd_cat = rd_word;
`endif
  assign load_val = extend(rd_f3, 32'(rd_cat >> {rd_off, 3'b000}));

  // NOTE: the RAM has no reset; its contents are undefined at power-up and
  // clearing it would force a flop array instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DMEM_MISALIGN_EN
          state_d = (!acc_err && misaligned) ? BEAT2 : RSP;
`else
          state_d = RSP;
`endif
        end
      end
`ifdef DMEM_MISALIGN_EN
      BEAT2:   state_d = RSP;
`endif
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers hold their value through RSP until the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || req_we) ? '0 : load_val;
    end
`ifdef DMEM_MISALIGN_EN
    else if (state_q == BEAT2) begin
      rsp_rdata <= we_q ? '0 : load_val;
    end
`endif
  end

`ifdef DMEM_MISALIGN_EN
  // Second-beat context captured at acceptance; lo_q keeps the first word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      hi_idx_q  <= '0;
      hi_be_q   <= 4'h0;
      hi_data_q <= '0;
      lo_q      <= '0;
    end else if (accept) begin
      we_q      <= req_we;
      f3_q      <= req_funct3;
      off_q     <= off;
      hi_idx_q  <= idx + IW'(1);
      hi_be_q   <= lane_mask[7:4];
      hi_data_q <= lane_data[63:32];
      lo_q      <= rd_word;
    end
  end
`endif

endmodule
